// File: rtl/text_mode_fetch_ctrl_pkg.sv
// Shared constants and CPU readback FSM encoding for the text-mode fetch controller.
package text_mode_fetch_ctrl_pkg;
    localparam int CHAR_W   = 8;
    localparam int GLYPH_H  = 8;
    localparam int FONT_AW  = 11;
    localparam int DEF_COLS = 40;
    localparam int DEF_ROWS = 25;

    typedef enum logic {
        CPU_IDLE = 1'b0,
        CPU_ACK  = 1'b1
    } cpu_state_e;
endpackage

// File: rtl/glyph_shifter.sv
// Parallel-load, left-shifting glyph row register; the valid flag tracks the loaded cell.
module glyph_shifter
    import text_mode_fetch_ctrl_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              load,
    input  logic [CHAR_W-1:0] din,
    input  logic              valid_in,
    output logic              pixel,
    output logic              pixel_valid
);
    logic [CHAR_W-1:0] shreg_q, shreg_d;
    logic              valid_q, valid_d;

    always_comb begin
        shreg_d = {shreg_q[CHAR_W-2:0], 1'b0};
        valid_d = valid_q;
        if (load) begin
            shreg_d = din;
            valid_d = valid_in;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            shreg_q <= '0;
            valid_q <= 1'b0;
        end else begin
            shreg_q <= shreg_d;
            valid_q <= valid_d;
        end
    end

    assign pixel       = shreg_q[CHAR_W-1];
    assign pixel_valid = valid_q;
endmodule

// File: rtl/text_mode_fetch_ctrl.sv
// Per-cell text fetch, font lookup and pixel serialisation, with the font ROM port
// shared by a CPU readback path that only gets cycles the display leaves free.
module text_mode_fetch_ctrl
    import text_mode_fetch_ctrl_pkg::*;
#(
    parameter int COLS    = DEF_COLS,
    parameter int ROWS    = DEF_ROWS,
    parameter int TEXT_AW = 11
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [9:0]         hpos,
    input  logic [9:0]         vpos,
    input  logic               display_on,
    output logic [TEXT_AW-1:0] text_addr,
    output logic               text_rd,
    input  logic [7:0]         text_data,
    output logic [FONT_AW-1:0] font_addr,
    input  logic [7:0]         font_data,
    input  logic               cpu_req,
    input  logic [FONT_AW-1:0] cpu_addr,
    output logic               cpu_ack,
    output logic [7:0]         cpu_data,
    output logic               pixel,
    output logic               pixel_valid
);
    localparam logic [9:0]         H_LIMIT  = 10'(COLS * CHAR_W);
    localparam logic [9:0]         V_LIMIT  = 10'(ROWS * GLYPH_H);
    localparam logic [TEXT_AW-1:0] ROW_STEP = TEXT_AW'(COLS);

    logic [2:0]         phase;
    logic [6:0]         col;
    logic               active_now;
    logic               disp_font;
    logic               cpu_grant;
    logic               cell_active_q, cell_active_d;
    logic [TEXT_AW-1:0] row_base_q, row_base_d;
    logic [7:0]         char_q, char_d;
    logic [7:0]         glyph_q, glyph_d;
    logic [7:0]         cpu_data_q, cpu_data_d;
    cpu_state_e         state_q, state_d;

    assign phase = hpos[2:0];
    assign col   = hpos[9:3];

    always_comb begin
        active_now    = display_on && (hpos < H_LIMIT) && (vpos < V_LIMIT);
        cell_active_d = (phase == 3'd0) ? active_now : cell_active_q;

        row_base_d = row_base_q;
        if (hpos == 10'd0) begin
            if (vpos == 10'd0) begin
                row_base_d = '0;
            end else if ((vpos[2:0] == 3'd0) && (vpos < V_LIMIT)) begin
                row_base_d = row_base_q + ROW_STEP;
            end
        end

        // Address from the next row base so the first cell of a new row already sees it.
        text_rd   = !reset && (phase == 3'd0) && active_now;
        text_addr = text_rd ? (row_base_d + TEXT_AW'(col)) : '0;

        char_d    = ((phase == 3'd1) && cell_active_q) ? text_data : char_q;
        disp_font = (phase == 3'd2) && cell_active_q;
        glyph_d   = disp_font ? font_data : glyph_q;
    end

    always_comb begin
        state_d   = state_q;
        cpu_grant = 1'b0;
        case (state_q)
            CPU_IDLE: begin
                if (cpu_req && !disp_font && !reset) begin
                    cpu_grant = 1'b1;
                    state_d   = CPU_ACK;
                end
            end
            CPU_ACK: state_d = CPU_IDLE;
        endcase

        cpu_data_d = cpu_grant ? font_data : cpu_data_q;

        if (disp_font) begin
            font_addr = {char_q, vpos[2:0]};
        end else if (cpu_grant) begin
            font_addr = cpu_addr;
        end else begin
            font_addr = '0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cell_active_q <= 1'b0;
            row_base_q    <= '0;
            char_q        <= '0;
            glyph_q       <= '0;
            cpu_data_q    <= '0;
            state_q       <= CPU_IDLE;
        end else begin
            cell_active_q <= cell_active_d;
            row_base_q    <= row_base_d;
            char_q        <= char_d;
            glyph_q       <= glyph_d;
            cpu_data_q    <= cpu_data_d;
            state_q       <= state_d;
        end
    end

    assign cpu_ack  = (state_q == CPU_ACK);
    assign cpu_data = cpu_data_q;

    glyph_shifter u_shifter (
        .clk         (clk),
        .reset       (reset),
        .load        (phase == 3'd7),
        .din         (cell_active_q ? glyph_q : 8'h00),
        .valid_in    (cell_active_q),
        .pixel       (pixel),
        .pixel_valid (pixel_valid)
    );
endmodule
